sram_array_1r1w_init: RTL
=========================

Name: sram_array_1r1w_init

Overview:
- Parametrised successor to the single-port masked array models used for cache and predictor storage.
- Provides one read port (R0) and one write port (W0) that can operate in the same cycle, with per-segment write masking.
- Adds configurable read latency, optional same-address write-to-read bypass and deterministic output hold.
- Adds a hardware zero-initialisation sweep after reset and on request, so arrays need no random-init model and have defined contents.

Parameters:
- DEPTH, 32, number of entries; any value ≥2.
- WIDTH, 256, bits per entry.
- MASK_SEG, 8, write-mask segments. WIDTH % MASK_SEG must be 0. Segment width SW = WIDTH/MASK_SEG.
- READ_LATENCY, 1, cycles from R0_en to R0_valid. Legal values are 1 or 2.
- BYPASS, 1, forwarding on a same-cycle read/write to the same address. 1 = forward new data; 0 = return old data.
- AW, $clog2(DEPTH), address width (derived).

Ports:
- clock  in  1  Sole clock, rising edge.
- reset_n  in  1  Asynchronous active-low reset.
- R0_en  in  1  Read request. Accepted only when init_done=1.
- R0_addr  in  AW  Read address. Must be < DEPTH.
- R0_valid  out  1  Single-cycle pulse: R0_rdata is updated this cycle.
- R0_rdata  out  WIDTH  Read data. Holds its last value between reads.
- W0_en  in  1  Write request. Accepted only when init_done=1.
- W0_addr  in  AW  Write address.
- W0_mask  in  MASK_SEG  Bit i enables write of segment [i*SW +: SW].
- W0_wdata  in  WIDTH  Write data.
- clear_req  in  1  Pulse: re-zero the whole array. Honoured only when init_done=1.
- init_done  out  1  1 = array is initialised and ports are usable.

Behaviour:
- Reset (async assert, sync release):
  - FSM = INIT, sweep counter = 0.
  - init_done = 0, R0_valid = 0, R0_rdata = 0.
  - All read pipeline valid bits = 0.
  - Array contents are not reset directly; the sweep clears them.
- FSM INIT:
  - Each cycle, write all-zero to entry[cnt], then cnt++.
  - When cnt == DEPTH-1 is written, go to READY the next cycle.
  - init_done rises exactly DEPTH cycles after reset release.
  - R0_en and W0_en are ignored (no write, no R0_valid).
- FSM READY:
  - init_done = 1.
  - clear_req=1 → go to INIT with cnt=0; init_done drops the next cycle.
  - A read and/or write presented in the same cycle as clear_req is still performed.
- Write: on a clock edge with W0_en && init_done, each segment i with W0_mask[i]=1 is updated. Unmasked segments keep their value. Mask = 0 is a no-op.
- Read:
  - R0_en && init_done at edge t samples the array at t. Contents seen are those before any write at edge t, except for the bypass case below.
  - READ_LATENCY=1: R0_rdata updates and R0_valid=1 for one cycle after edge t.
  - READ_LATENCY=2: the data passes through one extra output register; R0_valid is asserted one cycle later.
  - Back-to-back reads every cycle are fully pipelined.
- Same-cycle collision (R0_en && W0_en && R0_addr==W0_addr):
  - BYPASS=1: returned data per segment = W0_wdata when the mask bit is set, otherwise the old array value.
  - BYPASS=0: returned data = old array value.
  - In both cases the array is written normally.
- Output hold: R0_rdata changes only when R0_valid is asserted. It is never random or X after init.
- Reads in flight when clear_req is accepted still complete, with pre-clear data.
- Async reset mid-sweep or mid-read restarts from the full reset state. In-flight reads are dropped (no R0_valid).
- Out-of-range addresses (DEPTH not a power of 2): a write is dropped; a read returns 0 with R0_valid asserted.

Test Plan:
1. Release reset, DEPTH=32 → init_done=0 for 32 cycles then 1. A read of any addr 0..31 returns 256'h0 with R0_valid exactly 1 cycle (READ_LATENCY=1) after R0_en.
2. Write addr 5, mask 8'hFF, data {8{32'hA5A5A5A5}}. Next cycle write addr 5, mask 8'h01, data all 32'h11111111 in every segment. Then read addr 5 → low 32 bits 32'h11111111, upper 224 bits are A5A5A5A5 repeated.
3. BYPASS=1: read and write addr 9 in the same cycle (old = 0, mask 8'h80, wdata top segment 32'hDEADBEEF) → rdata[255:224]=32'hDEADBEEF, rest 0. With BYPASS=0 the same stimulus returns all 0; a follow-up read returns DEADBEEF in the top segment for both.
4. READ_LATENCY=2: reads on 4 consecutive cycles to addrs 0,1,2,3 (pre-written with their index) → R0_valid high for 4 consecutive cycles starting 2 cycles after the first read, data 0,1,2,3 in order. R0_rdata holds 3 afterwards.
5. After writing nonzero data to all entries, pulse clear_req → init_done low for 32 cycles. Writes and reads during this period are ignored. After init_done=1, every address reads 0.
6. Assert reset_n=0 at sweep cycle 10, release after 3 cycles → a full 32-cycle sweep runs again; R0_valid=0 and R0_rdata=0 throughout.

Source files
------------

// File: rtl/sram_array_1r1w_init.sv
// rtl/sram_array_1r1w_init.sv - 1R1W masked SRAM array with zero-init sweep, bypass and 1/2-cycle read latency
// Entries are cleared by a hardware sweep after reset or clear_req; ports are live only while init_done=1.
module sram_array_1r1w_init #(
  parameter int DEPTH        = 32,
  parameter int WIDTH        = 256,
  parameter int MASK_SEG     = 8,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1,
  localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int SW          = WIDTH / MASK_SEG
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                R0_en,
  input  logic [AW-1:0]       R0_addr,
  output logic                R0_valid,
  output logic [WIDTH-1:0]    R0_rdata,
  input  logic                W0_en,
  input  logic [AW-1:0]       W0_addr,
  input  logic [MASK_SEG-1:0] W0_mask,
  input  logic [WIDTH-1:0]    W0_wdata,
  input  logic                clear_req,
  output logic                init_done
);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];

  logic                rd_fire, wr_fire, rd_in_range, wr_in_range;
  logic [WIDTH-1:0]    rd_word;

  logic                p_valid_q, p_valid_d;
  logic [WIDTH-1:0]    p_data_q, p_data_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;

  assign init_done   = (state_q == ST_READY);
  assign rd_in_range = ({1'b0, R0_addr} < DEPTH_W);
  assign wr_in_range = ({1'b0, W0_addr} < DEPTH_W);
  assign rd_fire     = R0_en && init_done;
  assign wr_fire     = W0_en && init_done && wr_in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      default: begin
        if (clear_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array has no reset; the sweep owns the write port while in INIT.
  always_ff @(posedge clock) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < MASK_SEG; i++) begin
        if (W0_mask[i]) mem_q[W0_addr][i*SW +: SW] <= W0_wdata[i*SW +: SW];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[R0_addr];
      if ((BYPASS != 0) && wr_fire && (W0_addr == R0_addr)) begin
        for (int i = 0; i < MASK_SEG; i++) begin
          if (W0_mask[i]) rd_word[i*SW +: SW] = W0_wdata[i*SW +: SW];
        end
      end
    end
  end

  // Data registers load only with their valid, so R0_rdata holds between reads.
  always_comb begin
    p_valid_d   = rd_fire;
    p_data_d    = rd_fire ? rd_word : p_data_q;
    out_valid_d = rd_fire;
    out_data_d  = rd_fire ? rd_word : out_data_q;
    if (READ_LATENCY == 2) begin
      out_valid_d = p_valid_q;
      out_data_d  = p_valid_q ? p_data_q : out_data_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_valid_q   <= 1'b0;
      p_data_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      p_valid_q   <= p_valid_d;
      p_data_q    <= p_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign R0_valid = out_valid_q;
  assign R0_rdata = out_data_q;

endmodule
